fp_mult_result_fifo: RTL and testbench
======================================

# fp_mult_result_fifo

Downstream collection stage for the floating-point multiplier (mFPMult). Captures each valid product with its 3-bit output ID and exception flags into a small first-word-fall-through FIFO, and presents it to the consumer over a valid/ready handshake. A credit counter tells the operand source when it may issue, so results are never lost even though the multiplier pipeline cannot stall. Also checks that output IDs arrive in sequence and optionally keeps exception statistics.

## Interface
- pPrecision, 0, 0 = half, 1 = single, 2 = double; informational, must match the multiplier.
- pWidthExp, 5, exponent width.
- pWidthMan, 10, mantissa width; data width W = pWidthExp+pWidthMan+1.
- pDepth, 8, FIFO entries and initial credits; power of two, 2..64.

- i_Clk  in  1  clock; all state on rising edge.
- i_ARst  in  1  reset, asynchronous, active-high.
- i_Issue  in  1  operand pair issued to the multiplier this cycle (its i_Dv).
- o_IssueReady  out  1  at least one credit available.
- iv_Result  in  W  product from the multiplier.
- i3_OutputID  in  3  multiplier output ID; 0 = no result this cycle.
- i_Overflow, i_Underflow, i_NAN, i_PINF, i_NINF  in  1 each  multiplier flags, qualified by i3_OutputID != 0.
- ov_Data  out  W  head result.
- o3_ID  out  3  head ID.
- ov_Flags  out  5  head flags {NAN, PINF, NINF, Overflow, Underflow}.
- o_Valid  out  1  head entry valid.
- i_Ready  in  1  consumer accepts head when o_Valid is high.
- o_OvfErr  out  1  sticky: write dropped on full FIFO, or issue with zero credits.
- o_SeqErr  out  1  sticky: out-of-order output ID.
- i_StatClr  in  1  synchronous clear of sticky errors and counters.
- ov_OfCnt, ov_UfCnt, ov_NaNCnt  out  16 each  exception counters.

## Operation
- Push: i3_OutputID != 0. Entry stores {iv_Result, i3_OutputID, flags}.
- Pop: o_Valid && i_Ready.
- Push accepted if count < pDepth, or count == pDepth with a pop in the same cycle. Otherwise the entry is discarded and o_OvfErr is set.
- Credits: reset to pDepth. Issue alone decrements, pop alone increments, issue and pop together leave credits unchanged. o_IssueReady = (credits != 0).
- An issue when credits == 0 does not change credits and sets o_OvfErr.
- Credits never exceed pDepth. A pop at pDepth credits is impossible when the source honours o_IssueReady.
- Sequence check: expected ID resets to 1. Each push compares i3_OutputID to the expected ID and then advances expected as 1→2→…→7→1.
  - On mismatch, o_SeqErr is set and expected becomes (received ID)+1, wrapping 7→1.
  - The check runs whether or not the push is accepted.
- i_StatClr clears o_OvfErr, o_SeqErr and all counters. It does not touch FIFO contents, credits or the expected ID. If clear coincides with a set event, the set wins.

## Timing
- Reset values: o_Valid=0, ov_Data=0, o3_ID=0, ov_Flags=0, o_IssueReady=1, o_OvfErr=0, o_SeqErr=0, all counters 0. FIFO empty, credits=pDepth, expected ID=1.
- Push in cycle N: entry is visible at the head with o_Valid=1 in cycle N+1 (1-cycle latency).
- ov_Data, o3_ID and ov_Flags hold stable while o_Valid && !i_Ready.
- The next entry appears in the cycle after a pop.
- Empty FIFO: head outputs read 0, o_Valid=0.
- Push and pop on an empty FIFO in the same cycle: impossible (o_Valid=0).
- Read/write pointers wrap modulo pDepth. Full/empty are decided from an occupancy counter with log2(pDepth)+1 bits.
- Credit change is visible on o_IssueReady the cycle after the event.
- Reset mid-operation empties the FIFO and restores credits. In-flight multiplier results that arrive after reset are pushed and checked normally.

## Configuration
- FP_RESULT_STATS_EN defined:
  - ov_OfCnt counts accepted pushes with Overflow=1.
  - ov_UfCnt counts accepted pushes with Underflow=1.
  - ov_NaNCnt counts accepted pushes with NAN=1.
  - All counters saturate at 16'hFFFF.
- Not defined: the three counters are tied to 0 and no counter logic is built. FIFO, credits and error flags are unaffected.

## Test plan
- Reset, then issue 8 operands with i_Ready=0 → o_IssueReady falls the cycle after the 8th issue. Push IDs 1..7,1 → count=8, no errors.
- From full, a push without a pop → entry dropped, o_OvfErr=1. A push with a simultaneous pop → accepted, o_OvfErr unchanged.
- Push IDs 1,2,4 → o_SeqErr=1 after the third push. Then push 5 → no further effect, expected becomes 6. i_StatClr → o_SeqErr=0.
- Push 7 then 1 → wrap accepted, o_SeqErr stays 0.
- Push iv_Result=16'h7C00 with Overflow=1 and PINF=1 (pPrecision=0), i_Ready=1 → one cycle later ov_Data=16'h7C00 and ov_Flags=5'b01010. With FP_RESULT_STATS_EN, ov_OfCnt=1.
- Assert i_ARst while 3 entries are held → same cycle o_Valid=0 and o_IssueReady=1. After release, credits=8 and expected ID=1.

Source files
------------

// File: rtl/fp_mult_result_fifo_if.sv
// Result-path bundle between the FP multiplier, the collection FIFO and its consumer.
// The slave side is the FIFO; the master side is the multiplier/consumer environment.
interface fp_mult_result_fifo_if #(
  parameter int W = 16
);
  // Producer side: issue/credit handshake and the raw multiplier result.
  logic         i_Issue;
  logic         o_IssueReady;
  logic [W-1:0] iv_Result;
  logic [2:0]   i3_OutputID;
  logic         i_Overflow;
  logic         i_Underflow;
  logic         i_NAN;
  logic         i_PINF;
  logic         i_NINF;

  // Consumer side: head of the FIFO. A transfer happens on a cycle where
  // o_Valid && i_Ready; head fields stay stable while o_Valid && !i_Ready.
  logic [W-1:0] ov_Data;
  logic [2:0]   o3_ID;
  logic [4:0]   ov_Flags;
  logic         o_Valid;
  logic         i_Ready;

  modport slave (
    input  i_Issue, iv_Result, i3_OutputID,
    input  i_Overflow, i_Underflow, i_NAN, i_PINF, i_NINF,
    input  i_Ready,
    output o_IssueReady, ov_Data, o3_ID, ov_Flags, o_Valid
  );

  modport master (
    output i_Issue, iv_Result, i3_OutputID,
    output i_Overflow, i_Underflow, i_NAN, i_PINF, i_NINF,
    output i_Ready,
    input  o_IssueReady, ov_Data, o3_ID, ov_Flags, o_Valid
  );
endinterface

// File: rtl/fp_mult_result_fifo.sv
// FWFT result FIFO with issue credits and output-ID sequence checking for mFPMult.
// Define FP_RESULT_STATS_EN to build the saturating exception counters.
module fp_mult_result_fifo #(
  parameter int pPrecision = 0,
  parameter int pWidthExp  = 5,
  parameter int pWidthMan  = 10,
  parameter int pDepth     = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_ARst,
  fp_mult_result_fifo_if.slave  bus,
  output logic                  o_OvfErr,
  output logic                  o_SeqErr,
  input  logic                  i_StatClr,
  output logic [15:0]           ov_OfCnt,
  output logic [15:0]           ov_UfCnt,
  output logic [15:0]           ov_NaNCnt
);
  localparam int W  = pWidthExp + pWidthMan + 1;
  localparam int AW = $clog2(pDepth);
  localparam int CW = AW + 1;
  localparam int EW = W + 8;
  localparam logic [CW-1:0] DEPTH = CW'(pDepth);

  if (pPrecision < 0 || pPrecision > 2 || pDepth < 2 || pDepth > 64 ||
      (pDepth & (pDepth - 1)) != 0) begin : g_bad_param
    $error("fp_mult_result_fifo: unsupported parameter combination");
  end

  logic [EW-1:0] mem_q [pDepth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, credits_q, credits_d;
  logic [2:0]    exp_id_q, exp_id_d;
  logic          ovf_err_q, ovf_err_d, seq_err_q, seq_err_d;
  logic          push, pop, accept, issue_bad;
  logic [4:0]    flags_in;
  logic [EW-1:0] head;

  assign flags_in = {bus.i_NAN, bus.i_PINF, bus.i_NINF, bus.i_Overflow, bus.i_Underflow};

  always_comb begin
    push      = (bus.i3_OutputID != 3'd0);
    pop       = (count_q != '0) && bus.i_Ready;
    accept    = push && ((count_q < DEPTH) || pop);
    issue_bad = bus.i_Issue && (credits_q == '0);

    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);

    // Issue and pop together cancel; an issue with no credit is an error, not a decrement.
    credits_d = credits_q;
    if (bus.i_Issue && !pop && !issue_bad)                credits_d = credits_q - CW'(1);
    else if (pop && !bus.i_Issue && credits_q != DEPTH)   credits_d = credits_q + CW'(1);

    // Expected ID always resynchronises to received+1, match or not.
    exp_id_d = exp_id_q;
    if (push) exp_id_d = (bus.i3_OutputID == 3'd7) ? 3'd1 : bus.i3_OutputID + 3'd1;

    seq_err_d = i_StatClr ? 1'b0 : seq_err_q;
    if (push && bus.i3_OutputID != exp_id_q) seq_err_d = 1'b1;

    ovf_err_d = i_StatClr ? 1'b0 : ovf_err_q;
    if ((push && !accept) || issue_bad) ovf_err_d = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= DEPTH;
      exp_id_q  <= 3'd1;
      ovf_err_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      exp_id_q  <= exp_id_d;
      ovf_err_q <= ovf_err_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_Clk) begin
    if (accept) mem_q[wr_ptr_q] <= {bus.iv_Result, bus.i3_OutputID, flags_in};
  end

  assign head             = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.o_Valid      = (count_q != '0);
  assign bus.ov_Data      = head[EW-1:8];
  assign bus.o3_ID        = head[7:5];
  assign bus.ov_Flags     = head[4:0];
  assign bus.o_IssueReady = (credits_q != '0);
  assign o_OvfErr         = ovf_err_q;
  assign o_SeqErr         = seq_err_q;

`ifdef FP_RESULT_STATS_EN
  logic [15:0] of_cnt_q, of_cnt_d, uf_cnt_q, uf_cnt_d, nan_cnt_q, nan_cnt_d;

  always_comb begin
    of_cnt_d  = i_StatClr ? 16'd0 : of_cnt_q;
    uf_cnt_d  = i_StatClr ? 16'd0 : uf_cnt_q;
    nan_cnt_d = i_StatClr ? 16'd0 : nan_cnt_q;
    if (accept && bus.i_Overflow  && of_cnt_q  != 16'hFFFF) of_cnt_d  = of_cnt_q  + 16'd1;
    if (accept && bus.i_Underflow && uf_cnt_q  != 16'hFFFF) uf_cnt_d  = uf_cnt_q  + 16'd1;
    if (accept && bus.i_NAN       && nan_cnt_q != 16'hFFFF) nan_cnt_d = nan_cnt_q + 16'd1;
  end

  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      of_cnt_q  <= '0;
      uf_cnt_q  <= '0;
      nan_cnt_q <= '0;
    end else begin
      of_cnt_q  <= of_cnt_d;
      uf_cnt_q  <= uf_cnt_d;
      nan_cnt_q <= nan_cnt_d;
    end
  end

  assign ov_OfCnt  = of_cnt_q;
  assign ov_UfCnt  = uf_cnt_q;
  assign ov_NaNCnt = nan_cnt_q;
`else
  assign ov_OfCnt  = 16'd0;
  assign ov_UfCnt  = 16'd0;
  assign ov_NaNCnt = 16'd0;
`endif
endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// Directed table-driven bench for fp_mult_result_fifo (half precision, depth 8).
module tb_fp_mult_result_fifo;
  logic        clk;
  logic        rst;
  logic        stat_clr;
  logic        ovf_err, seq_err;
  logic [15:0] of_cnt, uf_cnt, nan_cnt;
  int          checks;
  int          errors;

  fp_mult_result_fifo_if #(.W(16)) bus ();

  fp_mult_result_fifo #(
    .pPrecision(0), .pWidthExp(5), .pWidthMan(10), .pDepth(8)
  ) dut (
    .i_Clk     (clk),
    .i_ARst    (rst),
    .bus       (bus),
    .o_OvfErr  (ovf_err),
    .o_SeqErr  (seq_err),
    .i_StatClr (stat_clr),
    .ov_OfCnt  (of_cnt),
    .ov_UfCnt  (uf_cnt),
    .ov_NaNCnt (nan_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        issue;
    logic [2:0]  id;
    logic [15:0] res;
    logic [4:0]  fl;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  eid;
    logic [4:0]  ef;
    logic        eir;
    logic        eovf;
    logic        eseq;
    logic [15:0] eof;
    logic [15:0] enan;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic issue, input logic [2:0] id, input logic [15:0] res,
                              input logic [4:0] fl, input logic rdy, input logic clr,
                              input logic ev, input logic [15:0] ed, input logic [2:0] eid,
                              input logic [4:0] ef, input logic eir, input logic eovf,
                              input logic eseq, input logic [15:0] eof, input logic [15:0] enan);
    vec_t v;
    v.issue = issue; v.id = id; v.res = res; v.fl = fl; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eid = eid; v.ef = ef; v.eir = eir; v.eovf = eovf;
    v.eseq = eseq; v.eof = eof; v.enan = enan;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input logic issue, input logic [2:0] id, input logic [15:0] res,
                       input logic [4:0] fl, input logic rdy, input logic clr);
    bus.i_Issue     = issue;
    bus.i3_OutputID = id;
    bus.iv_Result   = res;
    bus.i_NAN       = fl[4];
    bus.i_PINF      = fl[3];
    bus.i_NINF      = fl[2];
    bus.i_Overflow  = fl[1];
    bus.i_Underflow = fl[0];
    bus.i_Ready     = rdy;
    stat_clr        = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] sc;
    logic [15:0] id_res [8];
    checks = 0;
    errors = 0;
`ifdef FP_RESULT_STATS_EN
    sc = 16'd1;
`else
    sc = 16'd0;
`endif
    id_res[2] = 16'h4000; id_res[3] = 16'h4200; id_res[4] = 16'h4400;
    id_res[5] = 16'h4500; id_res[6] = 16'h4600; id_res[7] = 16'h4700;

    // Issue 8 with the consumer stalled; ready falls after the 8th.
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k < 8), 0, 0, 0, 0));
    // Fill with IDs 1..7,1.
    tbl.push_back(mk(0, 1, 16'h3C00, 0, 0, 0, 1, 16'h3C00, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k <= 7; k++)
      tbl.push_back(mk(0, 3'(k), id_res[k], 0, 0, 0, 1, 16'h3C00, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h4800, 0, 0, 0, 1, 16'h3C00, 1, 0, 0, 0, 0, 0, 0));
    // Full: push without pop drops, clear, then push with pop is accepted.
    tbl.push_back(mk(0, 2, 16'h4880, 0, 0, 0, 1, 16'h3C00, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h3C00, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 16'h4900, 0, 1, 0, 1, 16'h4000, 2, 0, 1, 0, 0, 0, 0));
    // Drain
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4200, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4400, 4, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4500, 5, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4600, 6, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4700, 7, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4800, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'h4900, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Sequence: expected is 4 here; 4,5 ok, 7 errors, 1 resyncs, clear.
    tbl.push_back(mk(0, 4, 16'h1111, 0, 1, 0, 1, 16'h1111, 4, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5, 16'h2222, 0, 1, 0, 1, 16'h2222, 5, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 7, 16'h3333, 0, 1, 0, 1, 16'h3333, 7, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h4444, 0, 1, 0, 1, 16'h4444, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2, 16'h5555, 0, 1, 1, 1, 16'h5555, 2, 0, 1, 0, 0, 0, 0));
    // Wrap 7 -> 1 without error.
    for (int k = 3; k <= 7; k++)
      tbl.push_back(mk(0, 3'(k), 16'h6000 + 16'(k), 0, 1, 0, 1, 16'h6000 + 16'(k), 3'(k), 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h8888, 0, 1, 0, 1, 16'h8888, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // +Inf with Overflow, then NaN; counters only when stats are built.
    tbl.push_back(mk(0, 2, 16'h7C00, 5'b01010, 1, 0, 1, 16'h7C00, 2, 5'b01010, 1, 0, 0, sc, 0));
    tbl.push_back(mk(0, 3, 16'h7E00, 5'b10000, 1, 0, 1, 16'h7E00, 3, 5'b10000, 1, 0, 0, sc, sc));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, sc, sc));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst valid", 32'(bus.o_Valid), 0);
    chk("rst data", 32'(bus.ov_Data), 0);
    chk("rst id", 32'(bus.o3_ID), 0);
    chk("rst flags", 32'(bus.ov_Flags), 0);
    chk("rst issue_ready", 32'(bus.o_IssueReady), 1);
    chk("rst ovf", 32'(ovf_err), 0);
    chk("rst seq", 32'(seq_err), 0);
    chk("rst counters", {of_cnt, uf_cnt | nan_cnt}, 0);
    step();
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      vec_t r;
      r = tbl[i];
      drive(r.issue, r.id, r.res, r.fl, r.rdy, r.clr);
      step();
      chk($sformatf("row%0d valid", i), 32'(bus.o_Valid), 32'(r.ev));
      chk($sformatf("row%0d data", i), 32'(bus.ov_Data), 32'(r.ed));
      chk($sformatf("row%0d id", i), 32'(bus.o3_ID), 32'(r.eid));
      chk($sformatf("row%0d flags", i), 32'(bus.ov_Flags), 32'(r.ef));
      chk($sformatf("row%0d issue_ready", i), 32'(bus.o_IssueReady), 32'(r.eir));
      chk($sformatf("row%0d ovf_err", i), 32'(ovf_err), 32'(r.eovf));
      chk($sformatf("row%0d seq_err", i), 32'(seq_err), 32'(r.eseq));
      chk($sformatf("row%0d of_cnt", i), 32'(of_cnt), 32'(r.eof));
      chk($sformatf("row%0d uf_cnt", i), 32'(uf_cnt), 0);
      chk($sformatf("row%0d nan_cnt", i), 32'(nan_cnt), 32'(r.enan));
    end

    // Mid-operation reset: 3 entries held and credits exhausted.
    for (int k = 4; k <= 6; k++) begin
      drive(1, 3'(k), 16'hA000 + 16'(k), 0, 0, 0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
    end
    chk("pre-rst valid", 32'(bus.o_Valid), 1);
    chk("pre-rst data", 32'(bus.ov_Data), 32'h0000A004);
    chk("pre-rst issue_ready", 32'(bus.o_IssueReady), 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid-rst valid", 32'(bus.o_Valid), 0);
    chk("mid-rst data", 32'(bus.ov_Data), 0);
    chk("mid-rst issue_ready", 32'(bus.o_IssueReady), 1);
    step();
    rst = 1'b0;

    // Credits back at 8 after reset.
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("post-rst issue%0d ready", k), 32'(bus.o_IssueReady), 32'(k < 8));
    end
    chk("post-rst ovf", 32'(ovf_err), 0);
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("zero-credit issue ovf", 32'(ovf_err), 1);
    chk("zero-credit issue ready", 32'(bus.o_IssueReady), 0);

    // Expected ID restarted at 1; a later gap is still caught.
    drive(0, 1, 16'hB001, 0, 1, 0);
    step();
    chk("post-rst id1 seq", 32'(seq_err), 0);
    chk("post-rst id1 head", {13'd0, bus.o3_ID, bus.ov_Data}, {13'd0, 3'd1, 16'hB001});
    drive(0, 2, 16'hB002, 0, 1, 0);
    step();
    chk("post-rst id2 seq", 32'(seq_err), 0);
    drive(0, 5, 16'hB005, 0, 1, 0);
    step();
    chk("post-rst gap seq", 32'(seq_err), 1);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("final empty", 32'(bus.o_Valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
